// File: rtl/gfx_pkg.sv
// Shared types and helpers for the gfx block: reader FSM states and line-offset width.
package gfx_pkg;

  typedef enum logic [1:0] {RDR_IDLE, RDR_BUS, RDR_RESP} gfx_rdr_state_e;

  // Byte-offset bits within one MDW-wide line; also used by gfx_calc_address.
  function automatic int line_off_bits(input int mdw);
    return $clog2(mdw / 8);
  endfunction

endpackage

// File: rtl/gfx_rdr_line_buf.sv
// Single-line tag/valid/data store with hit compare for the target reader.
// Instantiated only when GFX_TARGET_READER_CACHE_EN is defined.
module gfx_rdr_line_buf #(
  parameter int MDW  = 256,
  parameter int TAGW = 27
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fill_ok,
  input  logic            fill_err,
  input  logic            inval_i,
  input  logic [TAGW-1:0] fill_tag,
  input  logic [MDW-1:0]  fill_data,
  input  logic [TAGW-1:0] lookup_tag,
  output logic            hit,
  output logic [MDW-1:0]  line_q
);

  logic            valid_q;
  logic [TAGW-1:0] tag_q;

  // Invalidate beats a same-edge fill; a failed fill never leaves a stale line valid.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    valid_q <= 1'b0;
    else if (inval_i || fill_err) valid_q <= 1'b0;
    else if (fill_ok)             valid_q <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (fill_ok) begin
      tag_q  <= fill_tag;
      line_q <= fill_data;
    end
  end

  assign hit = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/gfx_wbm_target_reader.sv
// Wishbone B3 classic read master for the blender target-pixel fetch; always answers with ack_o.
// Optional single-line cache: define GFX_TARGET_READER_CACHE_EN.
module gfx_wbm_target_reader
  import gfx_pkg::*;
#(
  parameter int MDW     = 256,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  input  logic [MDW/8-1:0] sel_i,
  output logic             ack_o,
  output logic [MDW-1:0]   data_o,
  output logic             busy_o,
  output logic             err_o,
  input  logic             inval_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [2:0]       cti_o,
  output logic [1:0]       bte_o,
  output logic [31:0]      adr_o,
  output logic [MDW/8-1:0] sel_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [MDW-1:0]   dat_i
);

  localparam int SELW = MDW / 8;
  localparam int OFB  = line_off_bits(MDW);
  localparam int TAGW = 32 - OFB;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMAX       = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [31:0]    ALIGN_MASK = ~((32'd1 << OFB) - 32'd1);

  gfx_rdr_state_e  state_q, state_d;
  logic            cyc_q, cyc_d;
  logic [31:0]     adr_q, adr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [MDW-1:0]  data_q, data_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tmo;
  logic            hit;
  logic [MDW-1:0]  line_q;

  assign tmo = (TIMEOUT != 0) && (timer_q == TMAX);

`ifdef GFX_TARGET_READER_CACHE_EN
  logic fill_ok, fill_err;
  assign fill_ok  = (state_q == RDR_BUS) && ack_i;
  assign fill_err = (state_q == RDR_BUS) && !ack_i && (err_i || tmo);

  gfx_rdr_line_buf #(.MDW(MDW), .TAGW(TAGW)) u_line_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fill_ok    (fill_ok),
    .fill_err   (fill_err),
    .inval_i    (inval_i),
    .fill_tag   (adr_q[31:OFB]),
    .fill_data  (dat_i),
    .lookup_tag (addr_i[31:OFB]),
    .hit        (hit),
    .line_q     (line_q)
  );
`else
  logic unused_inval;
  assign unused_inval = inval_i;
  assign hit          = 1'b0;
  assign line_q       = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RDR_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    timer_d = timer_q;
    unique case (state_q)
      RDR_IDLE: begin
        if (req_i) begin
          if (hit && !inval_i) begin
            data_d  = line_q;
            ack_d   = 1'b1;
            state_d = RDR_RESP;
          end else begin
            adr_d   = addr_i & ALIGN_MASK;
            sel_d   = sel_i;
            cyc_d   = 1'b1;
            timer_d = '0;
            state_d = RDR_BUS;
          end
        end
      end
      RDR_BUS: begin
        if (ack_i) begin
          data_d  = dat_i;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = RDR_RESP;
        end else if (err_i || tmo) begin
          data_d  = '0;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = RDR_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RDR_RESP: state_d = RDR_IDLE;
      default:  state_d = RDR_IDLE;
    endcase
  end

  assign busy_o = (state_q != RDR_IDLE);
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign data_o = data_q;
  assign cyc_o  = cyc_q;
  assign stb_o  = cyc_q;
  assign we_o   = 1'b0;
  assign cti_o  = 3'b000;
  assign bte_o  = 2'b00;
  assign adr_o  = adr_q;
  assign sel_o  = sel_q;

endmodule
